// File: rtl/gpr_pkg.sv
// Shared definitions for the general-purpose register file: default sizes,
// FSM state encoding and the address-width helper.
package gpr_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } gpr_state_e;

  // Address width for a register count; at least one bit.
  function automatic int aw_of(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

endpackage

// File: rtl/gpr_file_if.sv
// Write/read bus of the register file. The master drives write ports and
// read addresses; the slave (register file) returns read data and Ready.
interface gpr_file_if
  import gpr_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = 2
) ();

  localparam int AW = aw_of(NREG);

  logic                 RegWr0;
  logic                 RegWr1;
  logic [AW-1:0]        Rw0;
  logic [AW-1:0]        Rw1;
  logic [XLEN-1:0]      busW0;
  logic [XLEN-1:0]      busW1;
  logic [NRD*AW-1:0]    Ra;
  logic [NRD*XLEN-1:0]  busR;
  logic                 Ready;

  modport master (
    output RegWr0, RegWr1, Rw0, Rw1, busW0, busW1, Ra,
    input  busR, Ready
  );

  modport slave (
    input  RegWr0, RegWr1, Rw0, Rw1, busW0, busW1, Ra,
    output busR, Ready
  );

endinterface

// File: rtl/gpr_init_seq.sv
// Post-reset clear sequencer: walks ClrIdx over every register once (INIT),
// then parks in RUN with a registered Ready flag.
module gpr_init_seq
  import gpr_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int AW   = aw_of(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic          init_o,
  output logic [AW-1:0] clr_idx_o,
  output logic          ready_o
);

  localparam logic [0:0]    S_INIT   = INIT;
  localparam logic [0:0]    S_RUN    = RUN;
  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic          ready_q, ready_d;

  // Next state: advance the sweep; the edge that clears the last register enters RUN.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ready_d   = ready_q;
    if (state_q == S_INIT) begin
      if (clr_idx_q == LAST_IDX) begin
        state_d   = S_RUN;
        ready_d   = 1'b1;
        clr_idx_d = '0;
      end else begin
        clr_idx_d = clr_idx_q + 1'b1;
      end
    end
  end

  // State registers; reset restarts the sweep from register 0 in any state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= S_INIT;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      ready_q   <= ready_d;
    end
  end

  assign init_o    = (state_q == S_INIT);
  assign clr_idx_o = clr_idx_q;
  assign ready_o   = ready_q;

endmodule

// File: rtl/gpr_file.sv
// Multi-ported register file: two write ports, NRD combinational read ports,
// optional hardwired-zero register 0, cleared by a sweep after reset.
// Optional feature macro: GPR_FILE_BYPASS_EN -- forwards same-cycle write
// data to matching read ports (write port 1 has priority).
module gpr_file
  import gpr_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = NREG_DEF,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1
) (
  input logic       WrClk,
  input logic       rst_n,
  gpr_file_if.slave bus
);

  localparam int AW = aw_of(NREG);

  logic [XLEN-1:0]     regs_q [NREG];
  logic                init;
  logic                ready;
  logic [AW-1:0]       clr_idx;
  logic                wr0_en;
  logic                wr1_en;
  logic [NRD*XLEN-1:0] rd_data;

  gpr_init_seq #(
    .NREG (NREG),
    .AW   (AW)
  ) u_init_seq (
    .clk_i     (WrClk),
    .rst_ni    (rst_n),
    .init_o    (init),
    .clr_idx_o (clr_idx),
    .ready_o   (ready)
  );

  assign bus.Ready = ready;

  // Writes take effect only in RUN; address 0 is dropped when hardwired to zero.
  assign wr0_en = ready && bus.RegWr0 && !((ZERO_REG != 0) && (bus.Rw0 == '0));
  assign wr1_en = ready && bus.RegWr1 && !((ZERO_REG != 0) && (bus.Rw1 == '0));

  // Storage update: reset clears reg 0, INIT clears one register per cycle,
  // RUN commits writes with port 1 ordered last so it wins on a collision.
  always_ff @(posedge WrClk) begin
    if (!rst_n) begin
      regs_q[0] <= '0;
    end else if (init) begin
      regs_q[clr_idx] <= '0;
    end else begin
      if (wr0_en) regs_q[bus.Rw0] <= bus.busW0;
      if (wr1_en) regs_q[bus.Rw1] <= bus.busW1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = bus.Ra[k*AW +: AW];

    // Combinational read with optional forwarding, zero register and INIT masking.
    always_comb begin
      data = regs_q[addr];
`ifdef GPR_FILE_BYPASS_EN
      if (wr0_en && (bus.Rw0 == addr)) data = bus.busW0;
      if (wr1_en && (bus.Rw1 == addr)) data = bus.busW1;
`endif
      if ((ZERO_REG != 0) && (addr == '0)) data = '0;
      if (!ready) data = '0;
    end

    assign rd_data[k*XLEN +: XLEN] = data;
  end

  assign bus.busR = rd_data;

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: two instances (ZERO_REG=1/NRD=2 and ZERO_REG=0/NRD=3)
// share write stimulus and are checked every cycle against an array model.
module tb_gpr_file;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD0 = 2;
  localparam int NRD1 = 3;

  logic WrClk = 1'b0;
  logic rst_n = 1'b0;
  always #5 WrClk = ~WrClk;

  logic               we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0]      rw0 = '0, rw1 = '0;
  logic [XLEN-1:0]    bw0 = '0, bw1 = '0;
  logic [NRD0*AW-1:0] ra0 = '0;
  logic [NRD1*AW-1:0] ra1 = '0;

  gpr_file_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD0)) if0 ();
  gpr_file_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD1)) if1 ();

  assign if0.RegWr0 = we0;  assign if1.RegWr0 = we0;
  assign if0.RegWr1 = we1;  assign if1.RegWr1 = we1;
  assign if0.Rw0    = rw0;  assign if1.Rw0    = rw0;
  assign if0.Rw1    = rw1;  assign if1.Rw1    = rw1;
  assign if0.busW0  = bw0;  assign if1.busW0  = bw0;
  assign if0.busW1  = bw1;  assign if1.busW1  = bw1;
  assign if0.Ra     = ra0;
  assign if1.Ra     = ra1;

  gpr_file #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD0), .ZERO_REG(1)) dut0 (
    .WrClk (WrClk), .rst_n (rst_n), .bus (if0));
  gpr_file #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD1), .ZERO_REG(0)) dut1 (
    .WrClk (WrClk), .rst_n (rst_n), .bus (if1));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // cnt = edges since reset release (saturating at NREG); the file is
  // usable exactly when cnt == NREG, and everything reads zero by then.
  logic [31:0] mem0 [NREG];
  logic [31:0] mem1 [NREG];
  int  cnt    = 0;
  bit  mvalid = 1'b0;

  always @(posedge WrClk) begin
    if (!rst_n) begin
      cnt    = 0;
      mvalid = 1'b1;
      for (int i = 0; i < NREG; i++) begin mem0[i] = '0; mem1[i] = '0; end
    end else if (cnt < NREG) begin
      cnt++;
    end else begin
      if (we0) begin if (rw0 != 0) mem0[rw0] = bw0; mem1[rw0] = bw0; end
      if (we1) begin if (rw1 != 0) mem0[rw1] = bw1; mem1[rw1] = bw1; end
    end
  end

  function automatic logic [31:0] exp_rd(input int which, input logic [AW-1:0] a);
    if (cnt != NREG) return 32'h0;
    if (which == 0 && a == 0) return 32'h0;
`ifdef GPR_FILE_BYPASS_EN
    if (we1 && rw1 == a) return bw1;
    if (we0 && rw0 == a) return bw0;
`endif
    return (which == 0) ? mem0[a] : mem1[a];
  endfunction

  // Every-cycle comparison of Ready and all read ports against the model.
  always @(negedge WrClk) begin
    if (mvalid) begin
      check("ready0", 32'(if0.Ready), 32'(cnt == NREG));
      check("ready1", 32'(if1.Ready), 32'(cnt == NREG));
      for (int k = 0; k < NRD0; k++)
        check($sformatf("dut0.busR[%0d]", k), if0.busR[k*XLEN +: XLEN], exp_rd(0, ra0[k*AW +: AW]));
      for (int k = 0; k < NRD1; k++)
        check($sformatf("dut1.busR[%0d]", k), if1.busR[k*XLEN +: XLEN], exp_rd(1, ra1[k*AW +: AW]));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge WrClk);
    #2;
  endtask

  task automatic idle();
    we0 = 1'b0;
    we1 = 1'b0;
  endtask

  task automatic set_ra(input logic [AW-1:0] a);
    ra0 = {NRD0{a}};
    ra1 = {NRD1{a}};
  endtask

  task automatic check_all(input string name, input logic [31:0] e0, input logic [31:0] e1);
    for (int k = 0; k < NRD0; k++) check({name, "_d0"}, if0.busR[k*XLEN +: XLEN], e0);
    for (int k = 0; k < NRD1; k++) check({name, "_d1"}, if1.busR[k*XLEN +: XLEN], e1);
  endtask

  logic [31:0]   byp_exp;
  logic [AW-1:0] r;

  initial begin
    // Sweep with writes attempted during INIT (must be ignored).
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    we0 = 1'b1; rw0 = 5'd3; bw0 = 32'hFF;
    we1 = 1'b1; rw1 = 5'd9; bw1 = 32'h1234_5678;
    #2 check("sweep_ready_c0", 32'(if0.Ready), 32'h0);
    for (int i = 1; i < NREG; i++) begin
      tick();
      #2 check("sweep_ready_lo", 32'(if0.Ready), 32'h0);
    end
    tick();
    idle();
    #2;
    check("sweep_ready_hi0", 32'(if0.Ready), 32'h1);
    check("sweep_ready_hi1", 32'(if1.Ready), 32'h1);
    for (int i = 0; i < NREG; i++) begin
      tick();
      r = AW'(i);
      set_ra(r);
      #2 check_all("sweep_zero", 32'h0, 32'h0);
    end

    // Mid-sweep reset at sweep cycle 10.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= NREG; i++) begin
      tick();
      #2 check("midsweep_ready", 32'(if0.Ready), 32'(i == NREG));
    end

    // Same-address dual write: port 1 wins.
    we0 = 1'b1; rw0 = 5'd5; bw0 = 32'h1111_1111;
    we1 = 1'b1; rw1 = 5'd5; bw1 = 32'h2222_2222;
    tick();
    idle();
    set_ra(5'd5);
    #2 check_all("dual_same", 32'h2222_2222, 32'h2222_2222);

    // Distinct-address dual write commits both.
    we0 = 1'b1; rw0 = 5'd10; bw0 = 32'hCAFE_0010;
    we1 = 1'b1; rw1 = 5'd11; bw1 = 32'hCAFE_0011;
    tick();
    idle();
    ra0 = {5'd11, 5'd10};
    #2;
    check("dual_dist_p0", if0.busR[31:0], 32'hCAFE_0010);
    check("dual_dist_p1", if0.busR[63:32], 32'hCAFE_0011);

    // Write to register 0.
    we0 = 1'b1; rw0 = 5'd0; bw0 = 32'hDEAD_BEEF;
    tick();
    idle();
    set_ra(5'd0);
    #2 check_all("zero_reg", 32'h0, 32'hDEAD_BEEF);

    // Same-cycle read of a register being written.
    we0 = 1'b1; rw0 = 5'd7; bw0 = 32'h1;
    tick();
    bw0 = 32'hA5A5_A5A5;
    set_ra(5'd7);
`ifdef GPR_FILE_BYPASS_EN
    byp_exp = 32'hA5A5_A5A5;
`else
    byp_exp = 32'h1;
`endif
    #2 check_all("same_cycle", byp_exp, byp_exp);
    tick();
    idle();
    #2 check_all("after_write", 32'hA5A5_A5A5, 32'hA5A5_A5A5);

    // Randomized traffic with occasional resets.
    repeat (1500) begin
      tick();
      rst_n = ($urandom_range(0, 299) != 0);
      we0 = 1'($urandom);
      we1 = 1'($urandom);
      rw0 = AW'($urandom);
      rw1 = ($urandom_range(0, 3) == 0) ? rw0 : AW'($urandom);
      bw0 = $urandom;
      bw1 = $urandom;
      for (int k = 0; k < NRD0; k++)
        ra0[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? rw1 : AW'($urandom);
      for (int k = 0; k < NRD1; k++)
        ra1[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? rw0 : AW'($urandom);
    end
    rst_n = 1'b1;
    idle();
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpr_file.md
GPR_FILE -- requirements
Module: gpr_file

Interface
REQ-001 SHALL have parameter XLEN, default 32, register width in bits.
REQ-002 SHALL have parameter NREG, default 32, register count, power of two, at least 2; AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, number of read ports, 1..4.
REQ-004 SHALL have parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL have port WrClk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port Ready, output, 1 bit: high once the init sweep is complete.
REQ-008 SHALL have ports RegWr0, RegWr1, input, 1 bit each: write enables, write ports 0 and 1.
REQ-009 SHALL have ports Rw0, Rw1, input, AW bits each: write addresses.
REQ-010 SHALL have ports busW0, busW1, input, XLEN bits each: write data.
REQ-011 SHALL have port Ra, input, NRD*AW bits: packed read addresses; port k occupies slice k.
REQ-012 SHALL have port busR, output, NRD*XLEN bits: packed read data; port k occupies slice k.

Function
REQ-013 SHALL have FSM states INIT and RUN.
REQ-014 In INIT, SHALL clear register ClrIdx each cycle, ClrIdx counting 0..NREG-1.
REQ-015 After clearing NREG-1, SHALL enter RUN on the next edge; Ready=1 in RUN only (registered, no combinational path).
REQ-016 SHALL take exactly NREG cycles from rst_n deasserting to Ready=1.
REQ-017 In INIT, SHALL ignore RegWr0/RegWr1, and all busR slices SHALL read 0.
REQ-018 In RUN, SHALL write busWn to Rwn at the edge when RegWrn=1.
REQ-019 If both ports write the same address in one cycle, port 1 SHALL win.
REQ-020 Distinct-address dual writes SHALL both commit in the same cycle.
REQ-021 With ZERO_REG=1, SHALL drop writes to address 0, and reads of address 0 SHALL return 0.
REQ-022 With ZERO_REG=0, register 0 SHALL behave as an ordinary register.
REQ-023 Reads SHALL be combinational (zero latency); any number of ports may read the same address.
REQ-024 Without bypass, a read of an address being written in the same cycle SHALL return the pre-edge value.

Reset
REQ-025 rst_n=0 at an edge SHALL force state INIT, ClrIdx=0, Ready=0, and register 0 cleared, in any state.
REQ-026 Reset asserted mid-sweep SHALL restart the sweep from 0.
REQ-027 Register contents other than 0 SHALL be undefined until the sweep clears them.

Configuration
REQ-028 SHALL provide macro GPR_FILE_BYPASS_EN.
REQ-029 With GPR_FILE_BYPASS_EN defined, in RUN, a read port whose address matches an enabled, non-dropped write SHALL return that write's data (port 1 data if both match).
REQ-030 Without GPR_FILE_BYPASS_EN, no bypass muxes SHALL exist and REQ-024 applies.

Structure
REQ-031 A shared package gpr_pkg SHALL hold: default XLEN and NREG constants, the FSM state enum (INIT, RUN), and a clog2-based AW helper.
REQ-032 One sub-module, gpr_init_seq, SHALL contain the FSM, ClrIdx counter and Ready; the storage array and read muxes stay in gpr_file.

Verification
REQ-033 Sweep: hold rst_n=0 for 3 cycles, then release -> Ready=0 for 32 cycles, then Ready=1; all 32 registers read 0.
REQ-034 Mid-sweep reset: pulse rst_n low at sweep cycle 10 -> Ready rises exactly 32 cycles after release.
REQ-035 Dual write to the same address: Rw0=Rw1=5 with busW0=0x11111111 and busW1=0x22222222 -> next cycle, reg 5 reads 0x22222222 on every port.
REQ-036 Zero register: write 0xDEADBEEF to address 0 -> all ports read 0 (ZERO_REG=1); repeat with ZERO_REG=0 -> reads 0xDEADBEEF.
REQ-037 Same-cycle read of written address: write 0xA5A5A5A5 to reg 7, which holds 0x1 -> Ra=7 returns 0xA5A5A5A5 with GPR_FILE_BYPASS_EN, 0x1 without it.
REQ-038 Writes during INIT: RegWr0=1, Rw0=3, busW0=0xFF -> after Ready, reg 3 reads 0.
